// File: rtl/buffer_fifo_ip.sv
// buffer_fifo_ip: synchronous first-word-fall-through FIFO.
//
// Parameters
//   WIDTH  data word width in bits (>=1)
//   DEPTH  capacity in words (power of two, >=2)
//   LVL_W  width of LEVEL (derived from DEPTH; leave at its default)
//
// Ports
//   CLOCK      single clock, rising edge
//   RESET      synchronous active-high reset
//   FLUSH      synchronous clear of contents and OVERFLOW
//   IN_DATA    write data
//   IN_VALID   write request
//   IN_READY   FIFO can accept a word this cycle (registered)
//   OUT_DATA   head-of-FIFO word (registered)
//   OUT_VALID  OUT_DATA holds a valid word
//   OUT_READY  consumer takes the word this cycle
//   LEVEL      words currently held, 0..DEPTH
//   FULL       LEVEL == DEPTH (registered)
//   EMPTY      LEVEL == 0 (registered)
//   OVERFLOW   sticky: a word was offered while full and dropped
//
// The head word lives in the OUT_DATA register; the remaining DEPTH-1 words live in a
// circular memory whose pointers wrap modulo DEPTH-1.
module buffer_fifo_ip #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [LVL_W-1:0] LEVEL,
  output logic             FULL,
  output logic             EMPTY,
  output logic             OVERFLOW
);

  localparam int unsigned MemDepth = DEPTH - 1;
  localparam int unsigned PtrW     = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  // Memory occupancy spans 0..DEPTH-1.
  localparam int unsigned CntW     = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MemDepth - 1);
  localparam logic [LVL_W-1:0] LvlFull = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [MemDepth];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  mem_cnt_q, mem_cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             in_ready_q, in_ready_d;
  logic             overflow_q, overflow_d;

  logic             wr, rd, mem_has, out_load, mem_pop, mem_push, wr_direct, mem_we;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
  endfunction

  always_comb begin
    wr        = IN_VALID & in_ready_q;
    rd        = out_valid_q & OUT_READY;
    mem_has   = (mem_cnt_q != '0);
    // Head register is free (empty or being consumed) this cycle.
    out_load  = ~out_valid_q | rd;
    mem_pop   = out_load & mem_has;
    // Only bypass the memory when it holds nothing older than the incoming word.
    wr_direct = wr & out_load & ~mem_has;
    mem_push  = wr & ~wr_direct;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    level_d     = level_q;
    full_d      = full_q;
    empty_d     = empty_q;
    in_ready_d  = in_ready_q;
    overflow_d  = overflow_q;
    mem_we      = 1'b0;

    if (RESET) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_cnt_d   = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      level_d     = '0;
      full_d      = 1'b0;
      empty_d     = 1'b1;
      in_ready_d  = 1'b0;
      overflow_d  = 1'b0;
    end else if (FLUSH) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_cnt_d   = '0;
      out_valid_d = 1'b0;
      level_d     = '0;
      full_d      = 1'b0;
      empty_d     = 1'b1;
      in_ready_d  = 1'b1;
      overflow_d  = 1'b0;
    end else begin
      if (mem_push) begin
        mem_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (mem_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      mem_cnt_d = mem_cnt_q + CntW'(mem_push) - CntW'(mem_pop);

      if (out_load) begin
        out_valid_d = mem_has | wr_direct;
        if (mem_has) begin
          out_data_d = mem_q[rd_ptr_q];
        end else if (wr_direct) begin
          out_data_d = IN_DATA;
        end
      end

      level_d    = level_q + LVL_W'(wr) - LVL_W'(rd);
      full_d     = (level_d == LvlFull);
      empty_d    = (level_d == '0);
      in_ready_d = ~full_d;
      overflow_d = overflow_q | (IN_VALID & full_q);
    end
  end

  always_ff @(posedge CLOCK) begin
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    mem_cnt_q   <= mem_cnt_d;
    out_data_q  <= out_data_d;
    out_valid_q <= out_valid_d;
    level_q     <= level_d;
    full_q      <= full_d;
    empty_q     <= empty_d;
    in_ready_q  <= in_ready_d;
    overflow_q  <= overflow_d;
  end

  // Storage needs no reset; occupancy tracking guards every read.
  always_ff @(posedge CLOCK) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= IN_DATA;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign LEVEL     = level_q;
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_buffer_fifo_ip.sv
// Self-checking bench for buffer_fifo_ip (WIDTH=8, DEPTH=4): directed steps followed by a
// random phase, all compared against a queue-based reference model.
module tb_buffer_fifo_ip;

  localparam int unsigned Width = 8;
  localparam int unsigned Depth = 4;
  localparam int unsigned LvlW  = $clog2(Depth + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic [Width-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LvlW-1:0]  level;
  logic             full;
  logic             empty;
  logic             overflow;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [Width-1:0] mq[$];
  bit               m_ovf = 1'b0;
  bit               m_rdy = 1'b0;

  buffer_fifo_ip #(
    .WIDTH(Width),
    .DEPTH(Depth)
  ) dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .FLUSH    (flush),
    .IN_DATA  (in_data),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .OUT_DATA (out_data),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .LEVEL    (level),
    .FULL     (full),
    .EMPTY    (empty),
    .OVERFLOW (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(mq.size()));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == Depth));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_rdy));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) chk({tag, ".out_data"}, 32'(out_data), 32'(mq[0]));
  endtask

  // One clock: apply inputs, advance the model at the edge, then compare everything.
  task automatic cyc(input string tag, input bit r, input bit f, input bit iv,
                     input logic [Width-1:0] d, input bit ordy);
    bit w;
    bit rdq;
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_rdy = 1'b0;
    end else if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_rdy = 1'b1;
    end else begin
      w   = iv && m_rdy;
      rdq = ordy && (mq.size() != 0);
      if (iv && mq.size() == Depth) m_ovf = 1'b1;
      if (rdq) void'(mq.pop_front());
      if (w) mq.push_back(d);
      m_rdy = (mq.size() < Depth);
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset held three cycles, then release.
    for (int i = 0; i < 3; i++) begin
      cyc("reset", 1, 0, 1, 8'hFF, 1);
      chk("reset.out_data_zero", 32'(out_data), 32'h0);
    end
    cyc("release", 0, 0, 0, 8'h00, 0);
    chk("release.in_ready", 32'(in_ready), 32'h1);
    cyc("idle", 0, 0, 0, 8'h00, 0);

    // Single word latency.
    cyc("a5_write", 0, 0, 1, 8'hA5, 0);
    chk("a5.out_data", 32'(out_data), 32'hA5);
    cyc("a5_hold", 0, 0, 0, 8'h00, 0);
    cyc("a5_read", 0, 0, 0, 8'h00, 1);
    chk("a5.empty_after", 32'(empty), 32'h1);

    // Fill to full, overflow, then drain in order.
    for (int i = 1; i <= 4; i++) cyc("fill", 0, 0, 1, 8'(i), 0);
    chk("fill.full", 32'(full), 32'h1);
    cyc("offer_05", 0, 0, 1, 8'h05, 0);
    chk("offer_05.overflow", 32'(overflow), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain.order", 32'(out_data), 32'(i));
      cyc("drain", 0, 0, 0, 8'h00, 1);
    end
    chk("drain.empty", 32'(empty), 32'h1);

    // Streaming with both sides always ready.
    for (int i = 0; i < 64; i++) cyc("stream", 0, 0, 1, 8'(8'h10 + i), 1);
    cyc("stream_tail", 0, 0, 0, 8'h00, 1);

    // Full plus simultaneous read.
    for (int i = 0; i < 4; i++) cyc("refill", 0, 0, 1, 8'(8'h60 + i), 0);
    cyc("full_rw", 0, 0, 1, 8'h77, 1);
    chk("full_rw.level", 32'(level), 32'h3);
    cyc("after_full_rw", 0, 0, 1, 8'h78, 0);
    cyc("pop_one", 0, 0, 0, 8'h00, 1);
    cyc("offer_full", 0, 0, 1, 8'h79, 0);
    cyc("offer_full2", 0, 0, 1, 8'h7A, 0);
    cyc("pop_two", 0, 0, 0, 8'h00, 1);

    // Flush with LEVEL=3 and OVERFLOW=1.
    chk("pre_flush.overflow", 32'(overflow), 32'h1);
    cyc("flush", 0, 1, 1, 8'hEE, 1);
    chk("flush.in_ready", 32'(in_ready), 32'h1);

    // Refill two words, then a one-cycle reset.
    cyc("refill2a", 0, 0, 1, 8'hC1, 0);
    cyc("refill2b", 0, 0, 1, 8'hC2, 0);
    cyc("mid_reset", 1, 0, 0, 8'h00, 0);
    chk("mid_reset.out_data_zero", 32'(out_data), 32'h0);
    cyc("post_reset", 0, 0, 1, 8'hD0, 1);
    cyc("post_reset2", 0, 0, 1, 8'hD1, 0);
    chk("post_reset.first", 32'(out_data), 32'hD1);
    cyc("post_reset3", 0, 0, 0, 8'h00, 1);

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      cyc("rand", ($urandom_range(99) == 0), ($urandom_range(49) == 0),
          ($urandom_range(3) != 0), 8'($urandom), ($urandom_range(2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
